// File: rtl/game_result_screen_ctrl.sv
// Game-over screen controller: latches the result, converts the game duration
// to BCD, blinks the winner banner and drives a registered pixel colour.
module game_result_screen_ctrl #(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          DUR_WIDTH    = 8,
  parameter int          DIGITS       = 3,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [7:0]  BG_COLOR     = 8'h00,
  parameter logic [7:0]  TITLE_COLOR  = 8'b001_101_11,
  parameter logic [7:0]  DUR_COLOR    = 8'b111_011_01,
  parameter logic [7:0]  WIN_COLOR    = 8'b011_000_11,
  localparam int         WID          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   game_over_flag,
  input  logic [WID-1:0]         winner_id,
  input  logic [DUR_WIDTH-1:0]   game_duration,
  input  logic                   frame_tick,
  input  logic                   res_title,
  input  logic                   res_duration,
  input  logic [NUM_PLAYERS-1:0] res_winner,
  input  logic                   restart_req,
  output logic [7:0]             pixel_color,
  output logic [4*DIGITS-1:0]    dur_digits,
  output logic                   digits_valid,
  output logic                   screen_active,
  output logic                   restart_ack
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);
  localparam int          CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int          BIT_W   = $clog2(DUR_WIDTH + 1);
  localparam int          NV      = 1 << WID;

  typedef enum logic [2:0] {IDLE, CAPTURE, CONVERT, SHOW, EXIT} state_t;

  state_t               state_q, state_d;
  logic                 prev_flag_q;
  logic [DUR_WIDTH-1:0] dur_reg_q, dur_reg_d;
  logic [WID-1:0]       winner_reg_q, winner_reg_d;
  logic                 winner_valid_q, winner_valid_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BCD_W-1:0]     dur_digits_q, dur_digits_d;
  logic                 digits_valid_q, digits_valid_d;
  logic                 screen_active_q, screen_active_d;
  logic                 restart_ack_q, restart_ack_d;
  logic                 blink_on_q, blink_on_d;
  logic [CNT_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic [7:0]           pixel_q, pixel_d;
  logic [NV-1:0]        win_vec;
  logic                 flag_rise;

  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] acc,
                                                   input logic in_bit);
    logic [BCD_W-1:0] adj;
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], in_bit};
  endfunction

  function automatic logic [DUR_WIDTH-1:0] sat_duration(input logic [DUR_WIDTH-1:0] d);
    if (32'(d) > MAX_VAL) return MAX_VAL[DUR_WIDTH-1:0];
    return d;
  endfunction

  assign flag_rise = game_over_flag & ~prev_flag_q;
  assign win_vec   = NV'(res_winner);

  always_comb begin
    state_d        = state_q;
    dur_reg_d      = dur_reg_q;
    winner_reg_d   = winner_reg_q;
    winner_valid_d = winner_valid_q;
    bcd_d          = bcd_q;
    bit_cnt_d      = bit_cnt_q;
    dur_digits_d   = dur_digits_q;
    blink_on_d     = 1'b1;
    blink_cnt_d    = '0;
    pixel_d        = BG_COLOR;

    case (state_q)
      IDLE:    if (flag_rise) state_d = CAPTURE;
      CAPTURE: begin
        dur_reg_d      = sat_duration(game_duration);
        winner_reg_d   = winner_id;
        winner_valid_d = (32'(winner_id) < NUM_PLAYERS);
        bcd_d          = '0;
        bit_cnt_d      = '0;
        state_d        = CONVERT;
      end
      CONVERT: begin
        bcd_d     = dabble_step(bcd_q, dur_reg_q[DUR_WIDTH-1]);
        dur_reg_d = dur_reg_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_W'(DUR_WIDTH - 1)) state_d = SHOW;
      end
      SHOW:    if (restart_req) state_d = EXIT;
      EXIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Dropping the flag aborts everything, even a simultaneous restart request.
    if (state_q != IDLE && !game_over_flag) state_d = IDLE;

    if (state_q == CONVERT && state_d == SHOW) dur_digits_d = bcd_d;

    if (state_q == SHOW && state_d == SHOW) begin
      blink_on_d  = blink_on_q;
      blink_cnt_d = blink_cnt_q;
      if (frame_tick) begin
        if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_on_d  = ~blink_on_q;
          blink_cnt_d = '0;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end

    screen_active_d = (state_d == SHOW);
    digits_valid_d  = (state_d == SHOW);
    restart_ack_d   = (state_d == EXIT);

    if (screen_active_q) begin
      if (res_title)                                          pixel_d = TITLE_COLOR;
      else if (res_duration)                                  pixel_d = DUR_COLOR;
      else if (blink_on_q && winner_valid_q && win_vec[winner_reg_q]) pixel_d = WIN_COLOR;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      dur_digits_q    <= '0;
      digits_valid_q  <= 1'b0;
      screen_active_q <= 1'b0;
      restart_ack_q   <= 1'b0;
      blink_on_q      <= 1'b1;
      blink_cnt_q     <= '0;
      pixel_q         <= BG_COLOR;
    end else begin
      state_q         <= state_d;
      dur_digits_q    <= dur_digits_d;
      digits_valid_q  <= digits_valid_d;
      screen_active_q <= screen_active_d;
      restart_ack_q   <= restart_ack_d;
      blink_on_q      <= blink_on_d;
      blink_cnt_q     <= blink_cnt_d;
      pixel_q         <= pixel_d;
    end
  end

  // Flag history keeps tracking through reset so a flag held high cannot retrigger.
  always_ff @(posedge clock) begin
    prev_flag_q    <= game_over_flag;
    dur_reg_q      <= dur_reg_d;
    winner_reg_q   <= winner_reg_d;
    winner_valid_q <= winner_valid_d;
    bcd_q          <= bcd_d;
    bit_cnt_q      <= bit_cnt_d;
  end

  assign pixel_color   = pixel_q;
  assign dur_digits    = dur_digits_q;
  assign digits_valid  = digits_valid_q;
  assign screen_active = screen_active_q;
  assign restart_ack   = restart_ack_q;

endmodule

// File: tb/tb_game_result_screen_ctrl.sv
// Bench for game_result_screen_ctrl: a default instance and a 3-player/2-digit
// instance share stimulus and are checked against a behavioural screen model.
module tb_game_result_screen_ctrl;

  localparam logic [7:0] BG    = 8'h00;
  localparam logic [7:0] TITLE = 8'b001_101_11;
  localparam logic [7:0] DURC  = 8'b111_011_01;
  localparam logic [7:0] WIN   = 8'b011_000_11;
  localparam int BF_A = 30;
  localparam int BF_B = 3;

  logic clock = 1'b0;
  always #20 clock = ~clock;

  logic       reset, game_over_flag, frame_tick, res_title, res_duration, restart_req;
  logic [7:0] game_duration;
  logic       winner_id_a;
  logic [1:0] res_winner_a;
  logic [1:0] winner_id_b;
  logic [2:0] res_winner_b;
  logic [7:0] pix_a, pix_b;
  logic [11:0] digits_a;
  logic [7:0]  digits_b;
  logic valid_a, valid_b, active_a, active_b, ack_a, ack_b;

  int n_pass = 0;
  int n_total = 0;
  int ticks = 0;
  int win_a = 0;
  int win_b = 0;
  int d3;

  game_result_screen_ctrl dut_a (
    .clock(clock), .reset(reset), .game_over_flag(game_over_flag),
    .winner_id(winner_id_a), .game_duration(game_duration), .frame_tick(frame_tick),
    .res_title(res_title), .res_duration(res_duration), .res_winner(res_winner_a),
    .restart_req(restart_req), .pixel_color(pix_a), .dur_digits(digits_a),
    .digits_valid(valid_a), .screen_active(active_a), .restart_ack(ack_a)
  );

  game_result_screen_ctrl #(.NUM_PLAYERS(3), .DIGITS(2), .BLINK_FRAMES(BF_B)) dut_b (
    .clock(clock), .reset(reset), .game_over_flag(game_over_flag),
    .winner_id(winner_id_b), .game_duration(game_duration), .frame_tick(frame_tick),
    .res_title(res_title), .res_duration(res_duration), .res_winner(res_winner_b),
    .restart_req(restart_req), .pixel_color(pix_b), .dur_digits(digits_b),
    .digits_valid(valid_b), .screen_active(active_b), .restart_ack(ack_b)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Decimal digits of the saturated duration, packed one nibble per digit.
  function automatic int exp_bcd(input int v, input int nd);
    int mx, r, dv;
    mx = 1;
    for (int i = 0; i < nd; i++) mx = mx * 10;
    mx = mx - 1;
    if (v > mx) v = mx;
    r = 0;
    dv = 1;
    for (int i = 0; i < nd; i++) begin
      r = r | (((v / dv) % 10) << (4 * i));
      dv = dv * 10;
    end
    return r;
  endfunction

  function automatic bit exp_blink(input int t, input int bf);
    return ((t / bf) % 2) == 0;
  endfunction

  function automatic logic [7:0] exp_pix(input bit active, input bit title, input bit dur,
                                         input bit blink, input bit wbit);
    if (!active) return BG;
    if (title) return TITLE;
    if (dur) return DURC;
    if (blink && wbit) return WIN;
    return BG;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_pix"}, pix_a, BG);
    check({tag, "_digits"}, digits_a, 0);
    check({tag, "_valid"}, valid_a, 0);
    check({tag, "_active"}, active_a, 0);
    check({tag, "_ack"}, ack_a, 0);
    check({tag, "_digits_b"}, digits_b, 0);
  endtask

  // One randomized pixel cycle while the screen is shown.
  task automatic rand_pix_cycle(input bit allow_tick);
    bit tick, wa, wb;
    logic [7:0] ea, eb;
    res_title    = ($urandom_range(0, 3) == 0);
    res_duration = ($urandom_range(0, 3) == 0);
    res_winner_a = 2'($urandom);
    res_winner_b = 3'($urandom);
    tick = allow_tick && ($urandom_range(0, 3) == 0);
    frame_tick = tick;
    wa = (win_a < 2) ? res_winner_a[win_a] : 1'b0;
    wb = (win_b < 3) ? res_winner_b[win_b] : 1'b0;
    ea = exp_pix(1'b1, res_title, res_duration, exp_blink(ticks, BF_A), wa);
    eb = exp_pix(1'b1, res_title, res_duration, exp_blink(ticks, BF_B), wb);
    step();
    check("rand_pix_a", pix_a, ea);
    check("rand_pix_b", pix_b, eb);
    frame_tick = 1'b0;
    if (tick) ticks++;
  endtask

  // Flag rises in cycle 0; SHOW is expected in cycle 10. Inputs are scrambled
  // after capture and a restart request lands mid-conversion.
  task automatic run_to_show(input int dur, input int wa, input int wb);
    game_duration = 8'(dur);
    winner_id_a = 1'(wa);
    winner_id_b = 2'(wb);
    res_title = 1'b0; res_duration = 1'b0; res_winner_a = '0; res_winner_b = '0;
    game_over_flag = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      restart_req = (c == 4);
      frame_tick  = (c == 3);
      if (c == 2) begin
        game_duration = 8'($urandom);
        winner_id_a = 1'($urandom);
        winner_id_b = 2'($urandom);
      end
      if (c == 9) check("active_before_show", active_a, 0);
    end
    restart_req = 1'b0;
    frame_tick = 1'b0;
    check("show_active_a", active_a, 1);
    check("show_active_b", active_b, 1);
    check("show_valid_a", valid_a, 1);
    check("show_valid_b", valid_b, 1);
    check("digits_a", digits_a, exp_bcd(dur, 3));
    check("digits_b", digits_b, exp_bcd(dur, 2));
    win_a = wa;
    win_b = wb;
    ticks = 0;
  endtask

  initial begin
    reset = 1'b1; game_over_flag = 1'b0; frame_tick = 1'b0; res_title = 1'b0;
    res_duration = 1'b0; restart_req = 1'b0; game_duration = '0;
    winner_id_a = '0; winner_id_b = '0; res_winner_a = '0; res_winner_b = '0;
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b0;
    step();

    run_to_show(47, 1, 3);
    res_winner_a = 2'b10; res_winner_b = 3'b111;
    step();
    check("winner1_pix_a", pix_a, WIN);
    check("draw_pix_b", pix_b, BG);
    repeat (40) rand_pix_cycle(1'b1);

    res_title = 1'b0; res_duration = 1'b0; res_winner_a = '0; res_winner_b = '0;
    restart_req = 1'b1;
    step();
    restart_req = 1'b0;
    check("exit_ack_a", ack_a, 1);
    check("exit_ack_b", ack_b, 1);
    check("exit_active", active_a, 0);
    check("exit_valid", valid_a, 0);
    step();
    check("ack_one_cycle", ack_a, 0);
    check("idle_active", active_a, 0);
    res_title = 1'b1;
    repeat (12) step();
    check("no_retrigger_held_flag", active_a, 0);
    check("idle_pix_bg", pix_a, BG);

    game_over_flag = 1'b0;
    step();
    run_to_show(255, 0, 1);
    res_winner_a = 2'b01; res_winner_b = 3'b010;
    for (int t = 1; t <= 60; t++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      ticks++;
      step();
      check("blink_a", pix_a, exp_pix(1'b1, 1'b0, 1'b0, exp_blink(ticks, BF_A), 1'b1));
      check("blink_b", pix_b, exp_pix(1'b1, 1'b0, 1'b0, exp_blink(ticks, BF_B), 1'b1));
      if (t == 30) check("blink_off_30", pix_a, BG);
      if (t == 60) check("blink_on_60", pix_a, WIN);
    end
    res_title = 1'b1; res_duration = 1'b1;
    step();
    check("title_priority", pix_a, TITLE);
    res_title = 1'b0;
    step();
    check("duration_color", pix_a, DURC);
    repeat (30) rand_pix_cycle(1'b1);

    game_over_flag = 1'b0;
    restart_req = 1'b1;
    step();
    restart_req = 1'b0;
    check("flag_low_wins_ack", ack_a, 0);
    check("flag_low_active", active_a, 0);
    check("flag_low_valid", valid_a, 0);
    step();
    check("flag_low_no_late_ack", ack_a, 0);

    d3 = int'($urandom_range(0, 255));
    game_duration = 8'(d3);
    game_over_flag = 1'b1;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_values("mid_convert_reset");
    repeat (15) step();
    check("held_flag_after_reset", active_a, 0);

    game_over_flag = 1'b0;
    step();
    game_over_flag = 1'b1;
    repeat (4) step();
    game_over_flag = 1'b0;
    repeat (10) step();
    check("abort_mid_convert", active_a, 0);

    run_to_show(d3, 1, 2);
    repeat (20) rand_pix_cycle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/game_result_screen_ctrl.md
Name: game_result_screen_ctrl

Overview:
- Parametrised successor to the two-player game-over renderer.
- Owns a game-over FSM that latches result data and converts game duration to BCD digits for the text renderers.
- Blinks the winner banner at a frame-based rate and drives a registered, non-latching pixel colour into vga_driver.
- Supports 2..4 players and clean restart handshaking with the top-level game FSM.

Parameters:
- NUM_PLAYERS, 2, number of players (2..4); sets width of res_winner and winner_id.
- DUR_WIDTH, 8, width of game_duration in bits (seconds).
- DIGITS, 3, number of BCD digits produced; MAX_VAL = 10^DIGITS-1.
- BLINK_FRAMES, 30, frame_tick count per blink half-period (≥1).
- BG_COLOR, 8'h00, background colour (RRR_GGG_BB).
- TITLE_COLOR, 8'b001_101_11, "Game Over" text colour.
- DUR_COLOR, 8'b111_011_01, duration line colour.
- WIN_COLOR, 8'b011_000_11, winner banner colour.

Ports:
- clock  in  1  25 MHz pixel clock.
- reset  in  1  synchronous, active-high reset.
- game_over_flag  in  1  level; high while the game is over.
- winner_id  in  WID=max(1,$clog2(NUM_PLAYERS))  index of winning player; ≥NUM_PLAYERS means draw.
- game_duration  in  DUR_WIDTH  elapsed seconds, binary.
- frame_tick  in  1  one-cycle pulse per frame (start of vsync).
- res_title  in  1  current pixel on "Game Over" glyph.
- res_duration  in  1  current pixel on duration line (incl. digits).
- res_winner  in  NUM_PLAYERS  bit p: current pixel on "Pp Wins" glyph.
- restart_req  in  1  one-cycle restart request from the game FSM/button.
- pixel_color  out  8  colour to vga_driver color_in.
- dur_digits  out  4*DIGITS  BCD duration, most-significant digit at top.
- digits_valid  out  1  dur_digits are stable and valid.
- screen_active  out  1  game-over screen is being displayed.
- restart_ack  out  1  one-cycle acknowledge of restart.

Behaviour:
- Reset values: pixel_color=BG_COLOR, dur_digits=0, digits_valid=0, screen_active=0, restart_ack=0. Internally blink_on=1, blink counter=0, state=IDLE.
- FSM states:
  - IDLE: edge detect on game_over_flag (registered prev). A rising edge goes to CAPTURE.
  - CAPTURE (1 cycle):
    - Latch game_duration into dur_reg; if it exceeds MAX_VAL, saturate to MAX_VAL.
    - Latch winner_id; winner_valid=(winner_id<NUM_PLAYERS).
    - Clear BCD accumulator and digits_valid. Go to CONVERT.
  - CONVERT: double-dabble, one input bit per cycle, MSB first. Exactly DUR_WIDTH cycles, then go to SHOW.
  - SHOW:
    - dur_digits loaded; digits_valid=1; screen_active=1; blink counter cleared, blink_on=1.
    - Each frame_tick increments the counter. When count reaches BLINK_FRAMES-1, toggle blink_on and clear the counter.
  - EXIT (1 cycle): restart_ack=1, screen_active=0, digits_valid=0. Go to IDLE.
- Transitions out of SHOW and the other non-IDLE states:
  - restart_req in SHOW goes to EXIT.
  - restart_req in CAPTURE or CONVERT is ignored.
  - game_over_flag low in any non-IDLE state goes to IDLE next cycle. No restart_ack; screen_active and digits_valid clear.
  - If restart_req and flag-low occur in the same cycle in SHOW, flag-low wins: IDLE, no ack.
- Latency: a flag edge sampled at cycle 0 gives CAPTURE at 1, CONVERT at 2..DUR_WIDTH+1, and SHOW with screen_active=digits_valid=1 at DUR_WIDTH+2.
- Pixel colour: registered, 1-cycle latency from the res_* inputs. Evaluated every cycle and never holds a stale value.
  - Not screen_active: BG_COLOR.
  - Otherwise, in priority order:
    - res_title gives TITLE_COLOR.
    - res_duration gives DUR_COLOR.
    - blink_on & winner_valid & res_winner[winner_reg] gives WIN_COLOR.
    - Anything else gives BG_COLOR.
  - res_winner bits other than the winner's are ignored. A draw shows no banner.
- Inputs are ignored outside the state that samples them. game_duration and winner_id changes after CAPTURE have no effect.
- A frame_tick during a non-SHOW state has no effect.
- Reset in any state, including mid-CONVERT, returns all outputs to their reset values on the next edge.
- A flag held high through reset does not retrigger; a fresh rising edge is required.

Test Plan:
- Defaults, game_duration=47, winner_id=1, flag rises at cycle 0.
  - Required: screen_active=1 at cycle 10, dur_digits=12'h047, digits_valid=1.
  - Required: with res_winner=2'b10 and the other res_* inputs low, pixel_color=8'b011_000_11 one cycle later.
- DIGITS=2, game_duration=255.
  - Required: dur_digits=8'h99 (saturated).
- In SHOW, winner_id=0, res_winner[0] held high, frame_tick pulsed.
  - Required: after 30 ticks pixel_color=BG_COLOR; after 60 ticks WIN_COLOR again.
  - Required: res_title and res_duration both high gives TITLE_COLOR.
- NUM_PLAYERS=3, winner_id=3 (draw), all res_winner high.
  - Required: pixel_color=BG_COLOR in SHOW.
- restart_req in SHOW.
  - Required: restart_ack=1 for exactly one cycle, then IDLE with screen_active=0.
  - Required: restart_req at cycle 4 (CONVERT) is ignored; SHOW is still reached at cycle 10.
- Reset asserted at cycle 5 (CONVERT) with flag held high.
  - Required: all outputs at reset values; no SHOW until the flag drops and rises again.
